no_riam_mc: RTL
===============

NO_RIAM_MC -- requirements
Module: no_riam_mc

Interface
REQ-001 Parameter WIDTH, default 1: state bits per channel (multi-valued node state).
REQ-002 Parameter CH, default 1: number of independent trajectory channels.
REQ-003 Parameter CNT_W, default 16: step-counter width per channel.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 reset_nos  in  CH  per-channel load of init_state into both copies.
REQ-007 start_s0  in  CH  per-channel slow-copy advance request.
REQ-008 start_s1  in  CH  per-channel fast-copy advance request.
REQ-009 init_state  in  CH*WIDTH  per-channel initial state; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 rap_s0  in  CH*WIDTH  next-state function result for slow copy.
REQ-011 rap_s1  in  CH*WIDTH  next-state function result for fast copy.
REQ-012 s0, s1  out  CH*WIDTH  registered slow and fast state copies.
REQ-013 riam_s0, riam_s1  out  CH*WIDTH  continuous copies of s0, s1.
REQ-014 meet  out  CH  registered sticky flag: slow and fast copies coincided.
REQ-015 steps  out  CH*CNT_W  registered fast-step count per channel.

Function (per channel c, channels fully independent)
REQ-016 Priority per edge: rst > reset_nos[c] > start_s0[c]/start_s1[c].
REQ-017 reset_nos[c]: s0[c]=s1[c]=init_state[c], pass[c]=1, meet[c]=0, steps[c]=0.
REQ-018 start_s0[c] with pass[c]=1: s0[c]<=rap_s0[c], pass[c]<=0.
REQ-019 start_s0[c] with pass[c]=0: s0[c] held, pass[c]<=1 (slow copy advances on 1st, 3rd, 5th... request after reset_nos).
REQ-020 start_s1[c]: s1[c]<=rap_s1[c] every request; no skip.
REQ-021 start_s0 and start_s1 may assert in the same cycle; both rules apply independently.
REQ-022 Define s0_n/s1_n as the values s0/s1 take at this edge; meet[c]<=1 when start_s1[c]=1 and s0_n==s1_n (full WIDTH compare).
REQ-023 meet[c] sticky until rst or reset_nos[c]; s0/s1 keep advancing after meet.
REQ-024 No comparison on cycles without start_s1[c]; equal states after reset_nos do not set meet.
REQ-025 Latency: s0, s1, meet, steps all valid one cycle after the requesting edge.

Reset
REQ-026 rst: s0=0, s1=0, pass=0, meet=0, steps=0 for every channel, regardless of other inputs.
REQ-027 rst mid-trajectory discards all state; pass=0 after rst, so first start_s0 after rst without reset_nos only sets pass.

Configuration
REQ-028 Macro NO_RIAM_STEP_CNT_EN defined: steps[c] increments by 1 on each start_s1[c] edge while meet[c]=0 (before the edge), saturates at 2^CNT_W-1, freezes once meet set; the meeting edge itself counts.
REQ-029 Macro undefined: no counter registers; steps driven constant 0.

Verification
REQ-030 WIDTH=4, CH=2: reset_nos=2'b11, init_state={4'h3,4'h5} -> next cycle s0=s1={4'h3,4'h5}, meet=0, steps=0.
REQ-031 Ch0: start_s0 and start_s1 every cycle for 4 cycles, rap_s0=rap_s1=4'h1,4'h2,4'h3,4'h4 -> s1 = 1,2,3,4; s0 = 1,1,3,3.
REQ-032 Ch0 from init 4'h5: start_s0+start_s1, rap_s0=4'h7, rap_s1=4'h7 -> s0=s1=7, meet[0]=1, steps[0]=1 (EN); ch1 unaffected, meet[1]=0.
REQ-033 CNT_W=2, EN, no meet: 5 start_s1 pulses -> steps 1,2,3,3,3.
REQ-034 reset_nos[0] and start_s1[0] same cycle, init 4'h9, rap_s1 4'hA -> s1[0]=9, meet=0, steps=0.
REQ-035 rst asserted with reset_nos and starts active -> all outputs 0 next cycle; then start_s0 alone -> s0 unchanged (pass 0->1).

Source files
------------

// File: rtl/no_riam_mc.sv
// Multi-channel slow/fast trajectory pair (Floyd-style cycle detection) with sticky meet flag.
// Optional per-channel fast-step counter enabled by defining NO_RIAM_STEP_CNT_EN.
module no_riam_mc #(
    parameter int WIDTH = 1,
    parameter int CH    = 1,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         reset_nos,
    input  logic [CH-1:0]         start_s0,
    input  logic [CH-1:0]         start_s1,
    input  logic [CH*WIDTH-1:0]   init_state,
    input  logic [CH*WIDTH-1:0]   rap_s0,
    input  logic [CH*WIDTH-1:0]   rap_s1,
    output logic [CH*WIDTH-1:0]   s0,
    output logic [CH*WIDTH-1:0]   s1,
    output logic [CH*WIDTH-1:0]   riam_s0,
    output logic [CH*WIDTH-1:0]   riam_s1,
    output logic [CH-1:0]         meet,
    output logic [CH*CNT_W-1:0]   steps
);

    logic [CH*WIDTH-1:0] s0_q, s0_d;
    logic [CH*WIDTH-1:0] s1_q, s1_d;
    logic [CH-1:0]       pass_q, pass_d;
    logic [CH-1:0]       meet_q, meet_d;

    always_comb begin
        s0_d   = s0_q;
        s1_d   = s1_q;
        pass_d = pass_q;
        meet_d = meet_q;
        for (int c = 0; c < CH; c++) begin
            if (reset_nos[c]) begin
                s0_d[c*WIDTH +: WIDTH] = init_state[c*WIDTH +: WIDTH];
                s1_d[c*WIDTH +: WIDTH] = init_state[c*WIDTH +: WIDTH];
                pass_d[c]              = 1'b1;
                meet_d[c]              = 1'b0;
            end else begin
                // Slow copy moves on every other request: pass marks the turn to advance.
                if (start_s0[c]) begin
                    if (pass_q[c]) begin
                        s0_d[c*WIDTH +: WIDTH] = rap_s0[c*WIDTH +: WIDTH];
                    end
                    pass_d[c] = ~pass_q[c];
                end
                if (start_s1[c]) begin
                    s1_d[c*WIDTH +: WIDTH] = rap_s1[c*WIDTH +: WIDTH];
                end
                if (start_s1[c] && (s0_d[c*WIDTH +: WIDTH] == s1_d[c*WIDTH +: WIDTH])) begin
                    meet_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q   <= '0;
            s1_q   <= '0;
            pass_q <= '0;
            meet_q <= '0;
        end else begin
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            pass_q <= pass_d;
            meet_q <= meet_d;
        end
    end

    assign s0      = s0_q;
    assign s1      = s1_q;
    assign riam_s0 = s0_q;
    assign riam_s1 = s1_q;
    assign meet    = meet_q;

`ifdef NO_RIAM_STEP_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CH*CNT_W-1:0] steps_q, steps_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    // The meeting edge itself is counted because meet_q is sampled before the edge.
    always_comb begin
        steps_d = steps_q;
        for (int c = 0; c < CH; c++) begin
            if (reset_nos[c]) begin
                steps_d[c*CNT_W +: CNT_W] = '0;
            end else if (start_s1[c] && !meet_q[c]) begin
                steps_d[c*CNT_W +: CNT_W] = sat_inc(steps_q[c*CNT_W +: CNT_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign steps = steps_q;
`else
    assign steps = '0;
`endif

endmodule
